// File: rtl/color_sensor_pkg.sv
// Shared types and defaults for the colour sensor frequency meter.
// Build macro CLEAR_CH_EN adds the unfiltered (clear) channel to the sweep.
package color_sensor_pkg;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_GATE_CYCLES   = 1000;
  localparam int DEF_SETTLE_CYCLES = 100;

`ifdef CLEAR_CH_EN
  localparam int N_CH = 4;
`else
  localparam int N_CH = 3;
`endif

  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_BLUE  = 2'd1,
    CH_CLEAR = 2'd2,
    CH_GREEN = 2'd3
  } channel_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    STORE,
    DONE
  } state_t;

  localparam channel_t LAST_CH = CH_GREEN;

  // Photodiode filter select code {s2,s3} for a channel.
  function automatic logic [1:0] filter_code(input channel_t ch);
    case (ch)
      CH_RED:   return 2'b00;
      CH_BLUE:  return 2'b01;
      CH_CLEAR: return 2'b10;
      default:  return 2'b11;
    endcase
  endfunction

  function automatic channel_t next_channel(input channel_t ch);
    case (ch)
      CH_RED:   return CH_BLUE;
`ifdef CLEAR_CH_EN
      CH_BLUE:  return CH_CLEAR;
      CH_CLEAR: return CH_GREEN;
`else
      CH_BLUE:  return CH_GREEN;
`endif
      default:  return CH_RED;
    endcase
  endfunction

endpackage

// File: rtl/color_freq_meter_edge_sync_det.sv
// Two-flop synchronizer followed by a one-cycle rising-edge pulse.
// Reusable for any asynchronous sensor pin.
module edge_sync_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/color_freq_meter.sv
// Period-gated edge counter sweeping the TCS3200 filters red/blue/(clear)/green.
// Build macro CLEAR_CH_EN enables the clear channel; otherwise clear_cnt and sat[3] stay 0.
module color_freq_meter
  import color_sensor_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             sensor_out,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic [3:0]       sat
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  channel_t         channel_q, channel_d;
  logic [TMR_W-1:0] timer_q;
  logic             timer_clr;
  logic             sweep_start;
  logic             store_en;
  logic             edge_pulse;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             meas_sat_q;
  logic [CNT_W-1:0] red_q, green_q, blue_q;
  logic [3:0]       sat_q;

  edge_sync_det u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (sensor_out),
    .rise_pulse (edge_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      channel_q <= CH_RED;
    end else begin
      state_q   <= state_d;
      channel_q <= channel_d;
    end
  end

  // Channel returns to red on entering DONE so s2/s3 idle at 00.
  always_comb begin
    state_d     = state_q;
    channel_d   = channel_q;
    timer_clr   = 1'b1;
    sweep_start = 1'b0;
    store_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SETTLE;
          channel_d   = CH_RED;
          sweep_start = 1'b1;
        end
      end
      SETTLE: begin
        timer_clr = 1'b0;
        if (timer_q == SETTLE_LAST) begin
          state_d   = MEASURE;
          timer_clr = 1'b1;
        end
      end
      MEASURE: begin
        timer_clr = 1'b0;
        if (timer_q == GATE_LAST) begin
          state_d   = STORE;
          timer_clr = 1'b1;
        end
      end
      STORE: begin
        store_en = 1'b1;
        if (channel_q == LAST_CH) begin
          state_d   = DONE;
          channel_d = CH_RED;
        end else begin
          state_d   = SETTLE;
          channel_d = next_channel(channel_q);
        end
      end
      DONE: begin
        if (cont) begin
          state_d     = SETTLE;
          channel_d   = CH_RED;
          sweep_start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (timer_clr) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // meas_sat_q marks that at least one edge was lost to the counter ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      meas_sat_q <= 1'b0;
    end else if (state_q == SETTLE) begin
      edge_cnt_q <= '0;
      meas_sat_q <= 1'b0;
    end else if (state_q == MEASURE && edge_pulse) begin
      if (edge_cnt_q == CNT_MAX) begin
        meas_sat_q <= 1'b1;
      end else begin
        edge_cnt_q <= edge_cnt_q + 1'b1;
      end
    end
  end

`ifdef CLEAR_CH_EN
  logic [CNT_W-1:0] clear_q;
`endif

  // sat bit order is {clear,blue,green,red}, not the enum order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
`ifdef CLEAR_CH_EN
      clear_q <= '0;
`endif
      sat_q   <= '0;
    end else if (sweep_start) begin
      sat_q <= '0;
    end else if (store_en) begin
      case (channel_q)
        CH_RED: begin
          red_q    <= edge_cnt_q;
          sat_q[0] <= meas_sat_q;
        end
        CH_GREEN: begin
          green_q  <= edge_cnt_q;
          sat_q[1] <= meas_sat_q;
        end
        CH_BLUE: begin
          blue_q   <= edge_cnt_q;
          sat_q[2] <= meas_sat_q;
        end
`ifdef CLEAR_CH_EN
        CH_CLEAR: begin
          clear_q  <= edge_cnt_q;
          sat_q[3] <= meas_sat_q;
        end
`endif
        default: ;
      endcase
    end
  end

  assign {s2, s3}  = filter_code(channel_q);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign red_cnt   = red_q;
  assign green_cnt = green_q;
  assign blue_cnt  = blue_q;
  assign sat       = sat_q;
`ifdef CLEAR_CH_EN
  assign clear_cnt = clear_q;
`else
  assign clear_cnt = '0;
`endif

endmodule

// File: tb/tb_color_freq_meter.sv
// Bench for color_freq_meter: a 16-bit and a 4-bit instance run in lockstep
// against an edge-timestamp model of the gate windows.
module tb_color_freq_meter;

  localparam int S = 10;
  localparam int G = 100;
  localparam int L = S + G + 1;
`ifdef CLEAR_CH_EN
  localparam int NCH = 4;
  localparam bit CLR_EN = 1'b1;
  int ord[4] = '{0, 1, 2, 3};
`else
  localparam int NCH = 3;
  localparam bit CLR_EN = 1'b0;
  int ord[3] = '{0, 1, 3};
`endif
  localparam int LAT = 1 + NCH * L;

  logic clk = 1'b0;
  logic rst_n, start, cont, sensor;

  logic        s2a, s3a, busya, donea;
  logic [15:0] reda, greena, bluea, cleara;
  logic [3:0]  sata;
  logic        s2b, s3b, busyb, doneb;
  logic [3:0]  redb, greenb, blueb, clearb;
  logic [3:0]  satb;

  color_freq_meter #(.CNT_W(16), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .sensor_out(sensor),
    .s2(s2a), .s3(s3a), .busy(busya), .done(donea),
    .red_cnt(reda), .green_cnt(greena), .blue_cnt(bluea), .clear_cnt(cleara), .sat(sata)
  );

  color_freq_meter #(.CNT_W(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .sensor_out(sensor),
    .s2(s2b), .s3(s3b), .busy(busyb), .done(doneb),
    .red_cnt(redb), .green_cnt(greenb), .blue_cnt(blueb), .clear_cnt(clearb), .sat(satb)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   edge_q[$];
  logic prev_sensor = 1'b0;
  int   ph;
  int   done_cyc, busy_drop, seq_len;
  logic [7:0] seq_v;
  logic [3:0] first_sat_b;
  int   idle_busy, idle_done;
  int   mc[4];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int period_of(input logic [1:0] code);
    case (code)
      2'b00:   return 4;
      2'b01:   return 20;
      2'b10:   return 2;
      default: return 10;
    endcase
  endfunction

  // Drives the sensor pin for the current cycle and timestamps rising edges.
  task automatic applyStimulus(input int mode, input int arg, input int c0);
    int p;
    case (mode)
      0: sensor = ((cyc + ph) % arg) < (arg / 2);
      1: begin
        p = period_of({s2a, s3a});
        sensor = ((cyc + ph) % p) < (p / 2);
      end
      2: sensor = $urandom_range(0, 99) < arg;
      3: sensor = (cyc == c0 + arg);
      default: sensor = 1'b0;
    endcase
    if (sensor && !prev_sensor) edge_q.push_back(cyc);
    prev_sensor = sensor;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      sensor = 1'b0;
      prev_sensor = 1'b0;
      step();
      if (busya) idle_busy++;
      if (donea) idle_done++;
    end
  endtask

  function automatic logic [15:0] obs_a(input int ch);
    case (ch)
      0: return reda;
      1: return bluea;
      2: return cleara;
      default: return greena;
    endcase
  endfunction

  function automatic logic [3:0] obs_b(input int ch);
    case (ch)
      0: return redb;
      1: return blueb;
      2: return clearb;
      default: return greenb;
    endcase
  endfunction

  // One sweep from the cycle in which start (or cont) is sampled, then model comparison.
  task automatic run_sweep(input int mode, input int arg, input bit use_start,
                           input bit cont_after, input bit noisy);
    int c0, last_code, code, lo, hi, e, eseq;
    bit seen;
    logic [3:0] es_a, es_b;
    c0 = cyc;
    edge_q.delete();
    seen = 1'b0;
    busy_drop = 0;
    seq_len = 0;
    seq_v = '0;
    last_code = -1;
    done_cyc = -1;
    ph = $urandom_range(0, 63);
    for (int n = 0; n < LAT + 8 && !seen; n++) begin
      start = (n == 0) ? use_start : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
      applyStimulus(mode, arg, c0);
      step();
      if (n == 0) begin
        cont = cont_after;
        first_sat_b = satb;
      end
      if (!busya) busy_drop++;
      if (donea) begin
        seen = 1'b1;
        done_cyc = cyc;
      end else begin
        code = int'({s2a, s3a});
        if (code != last_code) begin
          seq_v = {seq_v[5:0], 2'(code)};
          seq_len++;
          last_code = code;
        end
      end
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(seen), 1);
    checkOutput("latency", done_cyc - c0, LAT);
    checkOutput("busy_hold", busy_drop, 0);
    checkOutput("done_b", 32'(doneb), 1);
    eseq = 0;
    for (int i = 0; i < NCH; i++) eseq = (eseq << 2) | ord[i];
    checkOutput("filter_seq", (seq_len << 8) | int'(seq_v), (NCH << 8) | eseq);
    for (int ch = 0; ch < 4; ch++) mc[ch] = 0;
    for (int i = 0; i < NCH; i++) begin
      lo = c0 + i * L + S + 1;
      hi = lo + G - 1;
      foreach (edge_q[j]) if (edge_q[j] + 2 >= lo && edge_q[j] + 2 <= hi) mc[ord[i]]++;
    end
    for (int ch = 0; ch < 4; ch++) begin
      e = mc[ch];
      checkOutput($sformatf("cnt16_ch%0d", ch), 32'(obs_a(ch)), (e > 65535) ? 65535 : e);
      checkOutput($sformatf("cnt4_ch%0d", ch), 32'(obs_b(ch)), (e > 15) ? 15 : e);
    end
    es_a = {mc[2] > 65535, mc[1] > 65535, mc[3] > 65535, mc[0] > 65535};
    es_b = {mc[2] > 15, mc[1] > 15, mc[3] > 15, mc[0] > 15};
    checkOutput("sat16", 32'(sata), 32'(es_a));
    checkOutput("sat4", 32'(satb), 32'(es_b));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cont = 1'b0;
    sensor = 1'b0;
    idle_busy = 0;
    idle_done = 0;
    #1;
    checkOutput("rst_busy", 32'(busya), 0);
    checkOutput("rst_done", 32'(donea), 0);
    checkOutput("rst_s2s3", 32'({s2a, s3a}), 0);
    checkOutput("rst_red", 32'(reda), 0);
    checkOutput("rst_sat", 32'(sata), 0);
    checkOutput("rst_busy_b", 32'(busyb), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    checkOutput("idle_busy", idle_busy, 0);

    $display("[TB] fixed period 10");
    run_sweep(0, 10, 1'b1, 1'b0, 1'b0);
    checkOutput("fix_red", 32'(reda), 10);
    checkOutput("fix_blue", 32'(bluea), 10);
    checkOutput("fix_green", 32'(greena), 10);
    checkOutput("fix_clear", 32'(cleara), CLR_EN ? 10 : 0);
    idle(5);

    $display("[TB] per-channel period");
    run_sweep(1, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("pc_red", 32'(reda), 25);
    checkOutput("pc_blue", 32'(bluea), 5);
    checkOutput("pc_green", 32'(greena), 10);
    checkOutput("pc_clear", 32'(cleara), CLR_EN ? 50 : 0);
    checkOutput("pc_sat4", 32'(satb), CLR_EN ? 32'h9 : 32'h1);
    idle(5);

    $display("[TB] saturation then continuous sweep");
    run_sweep(0, 2, 1'b1, 1'b1, 1'b0);
    checkOutput("sat_red4", 32'(redb), 15);
    checkOutput("sat_green4", 32'(greenb), 15);
    checkOutput("sat_flags4", 32'(satb), CLR_EN ? 32'hF : 32'h7);
    checkOutput("sat_red16", 32'(reda), 50);
    run_sweep(0, 20, 1'b0, 1'b0, 1'b0);
    checkOutput("cont_sat_clr", 32'(first_sat_b), 0);
    checkOutput("cont_blue4", 32'(blueb), 5);
    checkOutput("cont_flags4", 32'(satb), 0);
    idle(5);

    $display("[TB] boundary edge");
    run_sweep(3, S + G - 2, 1'b1, 1'b0, 1'b0);
    checkOutput("edge_last_meas", 32'(reda), 1);
    idle(5);
    run_sweep(3, S + G - 1, 1'b1, 1'b0, 1'b0);
    checkOutput("edge_in_store", 32'(reda), 0);
    idle(5);

    $display("[TB] random density sweeps");
    for (int r = 0; r < 4; r++) begin
      run_sweep(2, $urandom_range(5, 60), 1'b1, 1'b0, 1'b0);
      idle($urandom_range(1, 6));
    end

    $display("[TB] reset during blue measurement");
    begin
      int c0;
      c0 = cyc;
      for (int n = 0; cyc < c0 + L + S + 50; n++) begin
        start = (n == 0);
        applyStimulus(0, 10, c0);
        step();
      end
      start = 1'b0;
      checkOutput("pre_rst_blue", 32'({s2a, s3a}), 1);
      checkOutput("pre_rst_red", 32'(reda), 10);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_busy", 32'(busya), 0);
      checkOutput("mid_rst_s2s3", 32'({s2a, s3a}), 0);
      checkOutput("mid_rst_red", 32'(reda), 0);
      checkOutput("mid_rst_red4", 32'(redb), 0);
      checkOutput("mid_rst_sat4", 32'(satb), 0);
      idle(3);
      rst_n = 1'b1;
      idle_busy = 0;
      idle(4);
      checkOutput("post_rst_idle", idle_busy, 0);
      run_sweep(0, 8, 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] start while busy");
    idle(3);
    run_sweep(2, 30, 1'b1, 1'b0, 1'b1);
    idle_busy = 0;
    idle_done = 0;
    idle(20);
    checkOutput("after_busy", idle_busy, 0);
    checkOutput("after_done", idle_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
